// File: rtl/tensor_buffer_arbiter_pkg.sv
// Shared types and helpers for the tensor-buffer arbiter slice.
// Optional feature macro: TB_ARB_AGING_EN (requester aging in the arbiter).
package tb_arb_pkg;

    // Power sequencing states; the encoding is visible on state_o.
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        GATED  = 2'd2,
        WAKE   = 2'd3
    } tb_arb_state_e;

    // Requester id width; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TB_ARB_NUM_REQ = 4;
    localparam int TB_ARB_ID_W    = id_width(TB_ARB_NUM_REQ);

endpackage

// File: rtl/tensor_buffer_arbiter_if.sv
// Requester and SRAM bus bundle for the tensor-buffer arbiter.
// Signal directions in the names are as seen from the arbiter (slave side).
interface tensor_buffer_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 16
);
    logic [NUM_REQ-1:0]              req_valid_i;
    logic [NUM_REQ-1:0]              req_ready_o;
    logic [NUM_REQ-1:0]              req_we_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i;
    logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i;
    logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wmask_i;
    logic [NUM_REQ-1:0]              rsp_valid_o;
    logic [DATA_WIDTH-1:0]           rsp_rdata_o;
    logic                            sram_we_no;
    logic [ADDR_WIDTH-1:0]           sram_addr_o;
    logic [DATA_WIDTH-1:0]           sram_wdata_o;
    logic [DATA_WIDTH/8-1:0]         sram_wmask_o;
    logic [DATA_WIDTH-1:0]           sram_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wmask_i, sram_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o,
        output sram_we_no, sram_addr_o, sram_wdata_o, sram_wmask_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wmask_i, sram_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o,
        input  sram_we_no, sram_addr_o, sram_wdata_o, sram_wmask_o
    );
endinterface

// File: rtl/tensor_buffer_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid at or above ptr_i, wrapping.
// With TB_ARB_AGING_EN, any aged requester overrides, lowest index first.
module tb_rr_arbiter
    import tb_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDW-1:0]     ptr_i,
`ifdef TB_ARB_AGING_EN
    input  logic [NUM_REQ-1:0] aged_i,
`endif
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDW-1:0]     idx_o,
    output logic               any_o
);

    // Rotating search from the pointer, then optional aging override.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_o && valid_i[(int'(ptr_i) + k) % NUM_REQ]) begin
                any_o = 1'b1;
                idx_o = IDW'((int'(ptr_i) + k) % NUM_REQ);
            end
        end
`ifdef TB_ARB_AGING_EN
        if (|aged_i) begin
            any_o = 1'b1;
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (aged_i[k]) idx_o = IDW'(k);
            end
        end
`endif
        if (any_o) grant_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/tensor_buffer_arbiter.sv
// Tensor-buffer SRAM port arbiter: round-robin grant, fixed-latency read
// return, and drain/gate/wake power sequencing of the SRAM.
// Optional feature macro: TB_ARB_AGING_EN (per-requester wait counters).
module tensor_buffer_arbiter
    import tb_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 512,
    parameter int ADDR_WIDTH  = 16,
    parameter int RD_LATENCY  = 1,
    parameter int WAKE_CYCLES = 16,
    parameter int AGE_LIMIT   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    tensor_buffer_arbiter_if.slave bus,
    input  logic                  pg_req_i,
    input  logic                  sram_power_ok_i,
    output logic                  sram_power_gate_o,
    output logic [1:0]            state_o,
    output logic                  busy_o
);

    localparam int IDW = id_width(NUM_REQ);
    localparam int BW  = DATA_WIDTH / 8;
    localparam int WCW = $clog2(WAKE_CYCLES + 1);
    localparam logic [WCW-1:0] WAKE_LAST = WCW'(WAKE_CYCLES - 1);

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_v;
    logic [NUM_REQ-1:0][BW-1:0]         wmask_v;

    assign addr_v  = bus.req_addr_i;
    assign wdata_v = bus.req_wdata_i;
    assign wmask_v = bus.req_wmask_i;

    tb_arb_state_e          state_q;
    logic [WCW-1:0]         wake_cnt_q;
    logic [IDW-1:0]         ptr_q;
    logic [IDW-1:0]         win_idx;
    logic [NUM_REQ-1:0]     win_oh;
    logic                   win_any;
    logic                   gnt;
    logic                   rd_issue;
    logic [NUM_REQ-1:0]     ready;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [BW-1:0]          wmask_q;
    logic [RD_LATENCY-1:0]  vld_pipe;
    logic [RD_LATENCY-1:0][IDW-1:0] id_pipe;

`ifdef TB_ARB_AGING_EN
    localparam int AW = $clog2(AGE_LIMIT + 1);
    logic [NUM_REQ-1:0] aged;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_age
        logic [AW-1:0] cnt_q;
        // Only a currently-valid requester may claim the aging override.
        assign aged[i] = bus.req_valid_i[i] && (cnt_q == AW'(AGE_LIMIT));
        // Wait counter: counts unserved valid cycles, saturating at the limit.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)                                 cnt_q <= '0;
            else if (!bus.req_valid_i[i] || ready[i])  cnt_q <= '0;
            else if (cnt_q != AW'(AGE_LIMIT))          cnt_q <= cnt_q + 1'b1;
        end
    end
`endif

    tb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .valid_i (bus.req_valid_i),
        .ptr_i   (ptr_q),
`ifdef TB_ARB_AGING_EN
        .aged_i  (aged),
`endif
        .grant_o (win_oh),
        .idx_o   (win_idx),
        .any_o   (win_any)
    );

    // Grants only in ACTIVE; reset also masks ready so it reads zero.
    assign gnt      = win_any && (state_q == ACTIVE) && !rst_i;
    assign ready    = gnt ? win_oh : '0;
    assign rd_issue = gnt && !bus.req_we_i[win_idx];
    assign bus.req_ready_o = ready;

    // SRAM command follows the winner; fields hold their last grant when idle.
    always_comb begin
        bus.sram_we_no   = 1'b1;
        bus.sram_addr_o  = addr_q;
        bus.sram_wdata_o = wdata_q;
        bus.sram_wmask_o = wmask_q;
        if (gnt) begin
            bus.sram_we_no   = ~bus.req_we_i[win_idx];
            bus.sram_addr_o  = addr_v[win_idx];
            bus.sram_wdata_o = wdata_v[win_idx];
            bus.sram_wmask_o = wmask_v[win_idx];
        end
    end

    // RR pointer and last-granted SRAM fields.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (gnt) begin
            ptr_q   <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
            addr_q  <= addr_v[win_idx];
            wdata_q <= wdata_v[win_idx];
            wmask_q <= wmask_v[win_idx];
        end
    end

    // Read-return shift register carrying {valid, requester id}.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[0] <= rd_issue;
            id_pipe[0]  <= win_idx;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
        end
    end

    // Registered response; read data holds between responses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.rsp_valid_o <= '0;
            bus.rsp_rdata_o <= '0;
        end else begin
            bus.rsp_valid_o <= '0;
            if (vld_pipe[RD_LATENCY-1]) begin
                bus.rsp_valid_o[id_pipe[RD_LATENCY-1]] <= 1'b1;
                bus.rsp_rdata_o <= bus.sram_rdata_i;
            end
        end
    end

    // Power FSM: drain in-flight reads, gate, then wake for a minimum time.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q           <= ACTIVE;
            wake_cnt_q        <= '0;
            sram_power_gate_o <= 1'b0;
        end else begin
            case (state_q)
                ACTIVE: if (pg_req_i) state_q <= DRAIN;
                DRAIN: if (!(|vld_pipe)) begin
                    state_q           <= GATED;
                    sram_power_gate_o <= 1'b1;
                end
                GATED: if (!pg_req_i) begin
                    state_q           <= WAKE;
                    sram_power_gate_o <= 1'b0;
                    wake_cnt_q        <= '0;
                end
                WAKE: begin
                    if (pg_req_i) begin
                        state_q           <= GATED;
                        sram_power_gate_o <= 1'b1;
                        wake_cnt_q        <= '0;
                    end else if (wake_cnt_q >= WAKE_LAST && sram_power_ok_i) begin
                        state_q    <= ACTIVE;
                        wake_cnt_q <= '0;
                    end else if (wake_cnt_q < WAKE_LAST) begin
                        wake_cnt_q <= wake_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ACTIVE;
            endcase
        end
    end

    assign state_o = state_q;
    assign busy_o  = !rst_i && ((|vld_pipe) || (|bus.req_valid_i));

endmodule

// File: tb/tb_tensor_buffer_arbiter.sv
// Directed bench for tensor_buffer_arbiter with a behavioural SRAM model.
// Build with TB_ARB_AGING_EN to include the aging sequence.
module tb_tensor_buffer_arbiter;

    localparam int NR = 4;
    localparam int DW = 512;
    localparam int AW = 16;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic pg_req_i = 1'b0;
    logic sram_power_ok_i = 1'b1;
    logic sram_power_gate_o;
    logic [1:0] state_o;
    logic busy_o;

    int tests = 0;
    int fails = 0;

    tensor_buffer_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    tensor_buffer_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .RD_LATENCY(1), .WAKE_CYCLES(16), .AGE_LIMIT(2)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .bus               (bus),
        .pg_req_i          (pg_req_i),
        .sram_power_ok_i   (sram_power_ok_i),
        .sram_power_gate_o (sram_power_gate_o),
        .state_o           (state_o),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Content of never-written SRAM words.
    function automatic logic [DW-1:0] pat(input int a);
        return {16{16'hC0DE, 16'(a)}};
    endfunction

    function automatic int oh2i(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return 0;
    endfunction

    // SRAM model: command sampled mid-cycle, applied at the edge, 1-cycle read.
    logic [DW-1:0]   mem [256];
    bit              written [256];
    logic            cmd_we_n = 1'b1;
    logic [7:0]      cmd_addr = '0;
    logic [DW-1:0]   cmd_wdata = '0;
    logic [DW/8-1:0] cmd_wmask = '0;

    initial bus.sram_rdata_i = '0;

    always @(negedge clk_i) begin
        cmd_we_n  <= bus.sram_we_no;
        cmd_addr  <= bus.sram_addr_o[7:0];
        cmd_wdata <= bus.sram_wdata_o;
        cmd_wmask <= bus.sram_wmask_o;
    end

    always @(posedge clk_i) begin : sram_model
        logic [DW-1:0] cur;
        cur = written[cmd_addr] ? mem[cmd_addr] : pat(int'(cmd_addr));
        bus.sram_rdata_i <= cur;
        if (!cmd_we_n) begin
            for (int b = 0; b < DW/8; b++)
                if (cmd_wmask[b]) cur[b*8 +: 8] = cmd_wdata[b*8 +: 8];
            mem[cmd_addr]     <= cur;
            written[cmd_addr] <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int r, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW/8-1:0] m);
        bus.req_we_i[r]                = we;
        bus.req_addr_i[r*AW +: AW]     = a;
        bus.req_wdata_i[r*DW +: DW]    = d;
        bus.req_wmask_i[r*DW/8 +: DW/8] = m;
    endtask

    typedef struct {
        logic [NR-1:0] vld;
        logic [NR-1:0] exp_rdy;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [NR-1:0] exp_v;
        logic [DW-1:0] exp_part;
        int bad;

        tbl[0]  = '{4'b1111, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0010};
        tbl[2]  = '{4'b1111, 4'b0100};
        tbl[3]  = '{4'b1111, 4'b1000};
        tbl[4]  = '{4'b1111, 4'b0001};
        tbl[5]  = '{4'b0001, 4'b0001};
        tbl[6]  = '{4'b0001, 4'b0001};
        tbl[7]  = '{4'b1001, 4'b1000};
        tbl[8]  = '{4'b1001, 4'b0001};
        tbl[9]  = '{4'b0000, 4'b0000};
        tbl[10] = '{4'b0110, 4'b0010};
        tbl[11] = '{4'b0101, 4'b0100};
        tbl[12] = '{4'b0011, 4'b0001};
        tbl[13] = '{4'b0000, 4'b0000};
        tbl[14] = '{4'b0000, 4'b0000};
        tbl[15] = '{4'b0000, 4'b0000};

        for (int r = 0; r < NR; r++) set_req(r, 1'b0, AW'(32 + r), '0, '0);
        bus.req_valid_i = 4'b1111;

        // Reset values while requests are pending
        @(negedge clk_i);
        chk("rst_ready", bus.req_ready_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_rdata", bus.rsp_rdata_o, 0);
        chk("rst_we_n", bus.sram_we_no, 1);
        chk("rst_addr", bus.sram_addr_o, 0);
        chk("rst_wdata", bus.sram_wdata_o, 0);
        chk("rst_wmask", bus.sram_wmask_o, 0);
        chk("rst_gate", sram_power_gate_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_state", state_o, 0);
        tick();
        bus.req_valid_i = '0;
        rst_i = 1'b0;
        tick();

        // Round-robin grant sequence with read returns two cycles later
        for (int i = 0; i < 16; i++) begin
            bus.req_valid_i = tbl[i].vld;
            @(negedge clk_i);
            chk($sformatf("grant[%0d]", i), bus.req_ready_o, tbl[i].exp_rdy);
            exp_v = '0;
            if (i >= 2) exp_v = tbl[i-2].exp_rdy;
            chk($sformatf("rsp_valid[%0d]", i), bus.rsp_valid_o, exp_v);
            if (exp_v != '0)
                chk($sformatf("rsp_data[%0d]", i), bus.rsp_rdata_o, pat(32 + oh2i(exp_v)));
            tick();
        end

        // Full write then read-after-write from another requester
        set_req(0, 1'b1, 16'h0010, {64{8'hA5}}, '1);
        set_req(1, 1'b0, 16'h0010, '0, '0);
        bus.req_valid_i = 4'b0001;
        @(negedge clk_i);
        chk("wr_ready", bus.req_ready_o, 4'b0001);
        chk("wr_we_n_low", bus.sram_we_no, 0);
        tick();
        bus.req_valid_i = 4'b0010;
        @(negedge clk_i);
        chk("raw_ready", bus.req_ready_o, 4'b0010);
        chk("raw_we_n_high", bus.sram_we_no, 1);
        tick();
        // Partial write: only byte 0 changes
        set_req(0, 1'b1, 16'h0010, {64{8'h3C}}, 64'h1);
        bus.req_valid_i = 4'b0001;
        @(negedge clk_i);
        chk("pwr_we_n_low", bus.sram_we_no, 0);
        tick();
        bus.req_valid_i = 4'b0010;
        @(negedge clk_i);
        chk("raw_rsp_valid", bus.rsp_valid_o, 4'b0010);
        chk("raw_rsp_data", bus.rsp_rdata_o, {64{8'hA5}});
        tick();
        bus.req_valid_i = '0;
        @(negedge clk_i);
        chk("idle_addr_hold", bus.sram_addr_o, 16'h0010);
        chk("idle_we_n", bus.sram_we_no, 1);
        tick();
        exp_part = {64{8'hA5}};
        exp_part[7:0] = 8'h3C;
        @(negedge clk_i);
        chk("part_rsp_valid", bus.rsp_valid_o, 4'b0010);
        chk("part_rsp_data", bus.rsp_rdata_o, exp_part);
        tick();

        // Power gate with a read in flight
        bus.req_valid_i = 4'b0100;
        pg_req_i = 1'b1;
        @(negedge clk_i);
        chk("pg_grant", bus.req_ready_o, 4'b0100);
        chk("pg_state_active", state_o, 0);
        tick();
        @(negedge clk_i);
        chk("drain_state", state_o, 1);
        chk("drain_no_ready", bus.req_ready_o, 0);
        chk("drain_busy", busy_o, 1);
        tick();
        @(negedge clk_i);
        chk("drain_rsp_valid", bus.rsp_valid_o, 4'b0100);
        chk("drain_rsp_data", bus.rsp_rdata_o, pat(32'h22));
        chk("drain_state2", state_o, 1);
        tick();
        @(negedge clk_i);
        chk("gated_state", state_o, 2);
        chk("gated_gate", sram_power_gate_o, 1);
        chk("gated_no_ready", bus.req_ready_o, 0);
        bus.req_valid_i = '0;
        pg_req_i = 1'b0;
        sram_power_ok_i = 1'b0;
        tick();
        @(negedge clk_i);
        chk("wake_state", state_o, 3);
        chk("wake_gate", sram_power_gate_o, 0);
        pg_req_i = 1'b1;
        tick();
        @(negedge clk_i);
        chk("rewake_gated", state_o, 2);
        pg_req_i = 1'b0;
        tick();

        // Wake with power-good arriving 20 cycles in
        bad = 0;
        for (int k = 0; k <= 20; k++) begin
            sram_power_ok_i = (k == 20);
            @(negedge clk_i);
            if (state_o != 2'd3) bad++;
            tick();
        end
        chk("wake_hold_cycles", bad, 0);
        @(negedge clk_i);
        chk("wake_done_active", state_o, 0);
        tick();

        // Reset in the middle of a read
        set_req(0, 1'b0, 16'h0020, '0, '0);
        bus.req_valid_i = 4'b0001;
        @(negedge clk_i);
        chk("mid_rd_grant", bus.req_ready_o, 4'b0001);
        tick();
        rst_i = 1'b1;
        bus.req_valid_i = '0;
        @(negedge clk_i);
        chk("mid_rst_rsp", bus.rsp_valid_o, 0);
        chk("mid_rst_rdata", bus.rsp_rdata_o, 0);
        chk("mid_rst_we_n", bus.sram_we_no, 1);
        chk("mid_rst_addr", bus.sram_addr_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        tick();
        @(negedge clk_i);
        chk("mid_rst_rsp2", bus.rsp_valid_o, 0);
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_rsp", bus.rsp_valid_o, 0);
        tick();
        bus.req_valid_i = 4'b1111;
        @(negedge clk_i);
        chk("rr_ptr_after_rst", bus.req_ready_o, 4'b0001);
        tick();
        bus.req_valid_i = 4'b1000;
        @(negedge clk_i);
        chk("rr_wrap_to_0", bus.req_ready_o, 4'b1000);
        tick();
        bus.req_valid_i = '0;

`ifdef TB_ARB_AGING_EN
        // Requester 3 ages through a power cycle, then beats RR pointer 0
        pg_req_i = 1'b1;
        tick();
        pg_req_i = 1'b0;
        sram_power_ok_i = 1'b1;
        bus.req_valid_i = 4'b1000;
        bad = 0;
        @(negedge clk_i);
        while (state_o != 2'd0 && bad < 60) begin
            @(negedge clk_i);
            bad++;
        end
        chk("age_wake_timeout", (bad < 60), 1);
        bus.req_valid_i = 4'b1001;
        #2;
        chk("age_override", bus.req_ready_o, 4'b1000);
        tick();
        @(negedge clk_i);
        chk("age_then_rr", bus.req_ready_o, 4'b0001);
        tick();
        bus.req_valid_i = '0;
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
